// File: rtl/arb_pkg.sv
// Shared FSM state type and sizing helper for the FIFO write arbiter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic int rr_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first valid index strictly after i_last, wrapping.
module rr_picker #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  i_valid,
  input  logic [ID_WIDTH-1:0] i_last,
  output logic [ID_WIDTH-1:0] o_next,
  output logic                o_found
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1'b1);

  // Mask of requester indices whose bit b is set, used to encode the one-hot winner.
  function automatic logic [NUM_REQ-1:0] id_bit_mask(input int b);
    logic [NUM_REQ-1:0] m;
    m = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      m = m | (NUM_REQ'((i >> b) & 1) << i);
    end
    return m;
  endfunction

  logic [NUM_REQ-1:0] w_above;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_pool;
  logic [NUM_REQ-1:0] w_onehot;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_above
    assign w_above[i] = (ID_WIDTH'(i) > i_last);
  end

  // Prefer indices above the last grant; fall back to the lowest valid when none remain.
  assign w_hi     = i_valid & w_above;
  assign w_pool   = (|w_hi) ? w_hi : i_valid;
  assign w_onehot = w_pool & (~w_pool + ONE);

  for (genvar b = 0; b < ID_WIDTH; b++) begin : g_enc
    assign o_next[b] = |(w_onehot & id_bit_mask(b));
  end

  assign o_found = |i_valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling per-requester beat streams into one external sync FIFO.
// A grant lasts one packet or MAX_BURST beats; every FIFO word is tagged with its source id.
module fifo_wr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  parameter int ID_WIDTH   = rr_idx_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy
);

  localparam logic [7:0]         BURST_END = 8'(MAX_BURST - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1'b1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [ID_WIDTH-1:0]   w_grant_id_nxt;
  logic [ID_WIDTH-1:0]   r_last_grant;
  logic [ID_WIDTH-1:0]   w_last_grant_nxt;
  logic [ID_WIDTH-1:0]   w_pick;
  logic [7:0]            r_beat_cnt;
  logic [7:0]            w_beat_cnt_nxt;
  logic                  w_found;
  logic                  w_in_grant;
  logic                  w_gnt_valid;
  logic                  w_gnt_last;
  logic                  w_xfer;
  logic                  w_release;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [DATA_WIDTH-1:0] w_payload;

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .i_valid (req_valid),
    .i_last  (r_last_grant),
    .o_next  (w_pick),
    .o_found (w_found)
  );

  // Reset gates the handshake at once so an interrupted burst writes nothing more.
  assign w_in_grant  = (r_state == ST_GRANT) && !rst;
  assign w_gnt_oh    = ONE_HOT_0 << r_grant_id;
  assign w_gnt_valid = |(req_valid & w_gnt_oh);
  assign w_gnt_last  = |(req_last & w_gnt_oh);
  assign w_payload   = DATA_WIDTH'(req_data >> (int'(r_grant_id) * DATA_WIDTH));

  assign req_ready  = (w_in_grant && !fifo_full) ? w_gnt_oh : {NUM_REQ{1'b0}};
  assign w_xfer     = w_in_grant && !fifo_full && w_gnt_valid;
  assign w_release  = w_xfer && (w_gnt_last || (r_beat_cnt == BURST_END));
  assign fifo_wr_en = w_xfer;
  assign fifo_din   = {r_grant_id, w_payload};
  assign grant_id   = r_grant_id;
  assign busy       = w_in_grant;

  // Next-state logic for the grant FSM and its burst bookkeeping.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ST_GRANT;
          w_grant_id_nxt = w_pick;
          w_beat_cnt_nxt = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant_id;
          w_beat_cnt_nxt   = 8'd0;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + 8'd1;
        end else begin
          w_beat_cnt_nxt = r_beat_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers; the last-grant reset value makes requester 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= {ID_WIDTH{1'b0}};
      r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
      r_beat_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter with 4 requesters and MAX_BURST = 4.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [IW+DW-1:0] fifo_din;
  logic [IW-1:0]    grant_id;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .ID_WIDTH   (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data = (req_data & ~(32'hFF << (i * DW))) | ({24'h0, v} << (i * DW));
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h0; fifo_full = 1'b0;
    tick(); tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    rst = 1'b0; req_valid = 4'b0000; req_last = 4'b0000;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111; req_last = 4'b1111; req_data = 32'h13121110; #1;
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rr_gap[%0d]: busy %b wr_en %b want 0 0", k, busy, fifo_wr_en); end
      tick();
      n_vec++; if (grant_id !== IW'(order[k])) begin n_err++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grant_id, order[k]); end
      n_vec++; if (fifo_wr_en !== 1'b1 || fifo_din !== {IW'(order[k]), 8'(8'h10 + order[k])}) begin
        n_err++; $display("FAIL rr_din[%0d]: wr_en %b din %h want 1 %h", k, fifo_wr_en, fifo_din, {IW'(order[k]), 8'(8'h10 + order[k])});
      end
      tick();
    end
    req_valid = 4'b0000; req_last = 4'b0000; #1;
  endtask

  task automatic test_packet();
    logic [7:0] beats [3] = '{8'hA1, 8'hA2, 8'hA3};
    req_valid = 4'b0100; req_last = 4'b0000; set_data(2, 8'hA1); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL pkt_idle: got %b want 0", busy); end
    tick();
    req_valid = 4'b0110;
    for (int b = 0; b < 3; b++) begin
      set_data(2, beats[b]);
      req_last = (b == 2) ? 4'b0100 : 4'b0000; #1;
      n_vec++; if (req_ready !== 4'b0100 || fifo_wr_en !== 1'b1 || fifo_din !== {2'd2, beats[b]}) begin
        n_err++; $display("FAIL pkt_beat[%0d]: ready %b wr_en %b din %h want 0100 1 %h", b, req_ready, fifo_wr_en, fifo_din, {2'd2, beats[b]});
      end
      tick();
    end
    req_last = 4'b0110; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL pkt_release: busy %b want 0", busy); end
    tick();
    n_vec++; if (grant_id !== 2'd1 || fifo_wr_en !== 1'b1 || fifo_din !== {2'd1, 8'h11}) begin
      n_err++; $display("FAIL pkt_next: grant %0d wr_en %b din %h want 1 1 %h", grant_id, fifo_wr_en, fifo_din, {2'd1, 8'h11});
    end
    tick();
    req_valid = 4'b0000; req_last = 4'b0000; #1;
  endtask

  task automatic test_max_burst();
    req_valid = 4'b0001; req_last = 4'b0000; set_data(0, 8'h40); #1;
    tick();
    for (int b = 0; b < MB; b++) begin
      n_vec++; if (busy !== 1'b1 || fifo_wr_en !== 1'b1 || fifo_din !== {2'd0, 8'(8'h40 + b)}) begin
        n_err++; $display("FAIL burst_beat[%0d]: busy %b wr_en %b din %h want 1 1 %h", b, busy, fifo_wr_en, fifo_din, {2'd0, 8'(8'h40 + b)});
      end
      tick();
      set_data(0, 8'(8'h41 + b)); #1;
    end
    n_vec++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
      n_err++; $display("FAIL burst_gap: busy %b wr_en %b ready %b want 0 0 0000", busy, fifo_wr_en, req_ready);
    end
    tick();
    req_last = 4'b0001; #1;
    n_vec++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_din !== {2'd0, 8'h44}) begin
      n_err++; $display("FAIL burst_regrant: busy %b grant %0d din %h want 1 0 %h", busy, grant_id, fifo_din, {2'd0, 8'h44});
    end
    tick();
    req_valid = 4'b0000; req_last = 4'b0000; #1;
  endtask

  task automatic test_full_stall();
    req_valid = 4'b1000; req_last = 4'b0000; set_data(3, 8'hC0); #1;
    tick();
    n_vec++; if (fifo_wr_en !== 1'b1 || fifo_din !== {2'd3, 8'hC0}) begin n_err++; $display("FAIL full_b0: wr_en %b din %h want 1 %h", fifo_wr_en, fifo_din, {2'd3, 8'hC0}); end
    tick(); set_data(3, 8'hC1); #1;
    n_vec++; if (fifo_wr_en !== 1'b1 || fifo_din !== {2'd3, 8'hC1}) begin n_err++; $display("FAIL full_b1: wr_en %b din %h want 1 %h", fifo_wr_en, fifo_din, {2'd3, 8'hC1}); end
    tick(); set_data(3, 8'hC2); fifo_full = 1'b1; #1;
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b1 || dut.r_beat_cnt !== 8'd2) begin
        n_err++; $display("FAIL full_stall[%0d]: ready %b wr_en %b busy %b cnt %0d want 0000 0 1 2", c, req_ready, fifo_wr_en, busy, dut.r_beat_cnt);
      end
      tick();
    end
    fifo_full = 1'b0; req_valid = 4'b0001; #1;
    for (int c = 0; c < 2; c++) begin
      n_vec++; if (busy !== 1'b1 || grant_id !== 2'd3 || fifo_wr_en !== 1'b0) begin
        n_err++; $display("FAIL hold_novalid[%0d]: busy %b grant %0d wr_en %b want 1 3 0", c, busy, grant_id, fifo_wr_en);
      end
      tick();
    end
    req_valid = 4'b1000; #1;
    n_vec++; if (req_ready !== 4'b1000 || fifo_wr_en !== 1'b1 || fifo_din !== {2'd3, 8'hC2}) begin
      n_err++; $display("FAIL full_resume: ready %b wr_en %b din %h want 1000 1 %h", req_ready, fifo_wr_en, fifo_din, {2'd3, 8'hC2});
    end
    tick(); set_data(3, 8'hC3); #1;
    n_vec++; if (fifo_wr_en !== 1'b1 || fifo_din !== {2'd3, 8'hC3}) begin n_err++; $display("FAIL full_b3: wr_en %b din %h want 1 %h", fifo_wr_en, fifo_din, {2'd3, 8'hC3}); end
    tick();
    req_valid = 4'b0000; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_release: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; req_last = 4'b0000; set_data(2, 8'hD0); #1;
    tick();
    n_vec++; if (fifo_wr_en !== 1'b1 || fifo_din !== {2'd2, 8'hD0}) begin n_err++; $display("FAIL rstmid_b0: wr_en %b din %h want 1 %h", fifo_wr_en, fifo_din, {2'd2, 8'hD0}); end
    tick(); set_data(2, 8'hD1); rst = 1'b1; req_valid = 4'b0101; #1;
    n_vec++; if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_during: wr_en %b busy %b ready %b want 0 0 0000", fifo_wr_en, busy, req_ready);
    end
    tick(); rst = 1'b0; #1;
    n_vec++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || grant_id !== 2'd0) begin
      n_err++; $display("FAIL rstmid_after: busy %b wr_en %b grant %0d want 0 0 0", busy, fifo_wr_en, grant_id);
    end
    tick(); req_last = 4'b0001; #1;
    n_vec++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_din !== {2'd0, 8'h44}) begin
      n_err++; $display("FAIL rstmid_regrant: busy %b grant %0d din %h want 1 0 %h", busy, grant_id, fifo_din, {2'd0, 8'h44});
    end
    tick();
    req_valid = 4'b0000; req_last = 4'b0000; #1;
  endtask

  task automatic test_random();
    logic [7:0]    seq    [NR];
    int            rem    [NR];
    int            wait_c [NR];
    logic [NR-1:0] pend;
    logic [NR-1:0] acc;
    logic [NR-1:0] v;
    logic [NR-1:0] l;
    logic [NR*DW-1:0] d;
    logic          prev_busy;
    for (int i = 0; i < NR; i++) begin seq[i] = 8'(i * 64); rem[i] = 0; wait_c[i] = 0; end
    pend = 4'b0000; prev_busy = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      v = 4'b0000; l = 4'b0000; d = 32'h0;
      for (int i = 0; i < NR; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 6);
        if (rem[i] > 0) v = v | (4'b0001 << i);
        if (rem[i] == 1) l = l | (4'b0001 << i);
        d = d | ({24'h0, seq[i]} << (i * DW));
      end
      req_valid = v; req_last = l; req_data = d; fifo_full = ($urandom_range(0, 4) == 0);
      #1;
      if (busy && !prev_busy) begin
        for (int i = 0; i < NR; i++) begin
          if (pend[0]) begin
            if (IW'(i) == grant_id) wait_c[i] = 0;
            else begin
              wait_c[i]++;
              n_vec++; if (wait_c[i] > NR - 1) begin n_err++; $display("FAIL rnd_fair: req %0d waited %0d grants want <= %0d", i, wait_c[i], NR - 1); end
            end
          end
          pend = pend >> 1;
        end
      end
      if (!busy) pend = v;
      n_vec++; if (fifo_wr_en === 1'b1 && fifo_full === 1'b1) begin n_err++; $display("FAIL rnd_full_write: cycle %0d wr_en 1 while full", c); end
      acc = req_ready & v;
      n_vec++; if (fifo_wr_en !== (acc != 4'b0000) || $countones(acc) > 1) begin
        n_err++; $display("FAIL rnd_strobe: cycle %0d wr_en %b accepts %b", c, fifo_wr_en, acc);
      end
      for (int i = 0; i < NR; i++) begin
        if (acc[0]) begin
          n_vec++; if (fifo_din !== {IW'(i), seq[i]}) begin
            n_err++; $display("FAIL rnd_order: cycle %0d din %h want %h", c, fifo_din, {IW'(i), seq[i]});
          end
          seq[i] = seq[i] + 8'd1;
          rem[i] = rem[i] - 1;
        end
        acc = acc >> 1;
      end
      prev_busy = busy;
      tick();
    end
    req_valid = 4'b0000; req_last = 4'b0000; fifo_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet();
    test_max_burst();
    test_full_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: payload width per beat.
REQ-003 Parameter MAX_BURST, default 8: max beats per grant, 1..256.
REQ-004 Parameter ID_WIDTH, default $clog2(NUM_REQ): requester-index width.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by valid.
REQ-010 req_ready  output  NUM_REQ  per-requester beat accept.
REQ-011 fifo_full  input  1  full flag from the downstream sync FIFO.
REQ-012 fifo_wr_en  output  1  downstream FIFO write strobe.
REQ-013 fifo_din  output  ID_WIDTH+DATA_WIDTH  {grant_id, payload} written to the FIFO.
REQ-014 grant_id  output  ID_WIDTH  currently granted requester.
REQ-015 busy  output  1  high while in GRANT.

Function
REQ-016 States: IDLE and GRANT.
REQ-017 IDLE: if any req_valid is high, select the first valid requester in round-robin order, starting at (last_grant+1) mod NUM_REQ. Register it in grant_id and enter GRANT on the next edge. Latency is one cycle.
REQ-018 In IDLE, all req_ready bits are 0 and fifo_wr_en is 0.
REQ-019 In GRANT: req_ready[i] = (i==grant_id) && !fifo_full (combinational). All other ready bits are 0.
REQ-020 Beat transfer = req_valid[grant_id] && req_ready[grant_id]. fifo_wr_en equals transfer, combinationally. fifo_din = {grant_id, req_data of grant_id}.
REQ-021 An 8-bit beat counter resets to 0 on entry to GRANT and increments on each transfer.
REQ-022 GRANT -> IDLE on the edge of a transfer where req_last is 1 or the counter equals MAX_BURST-1. Simultaneous last and max cause a single release. On release, last_grant takes grant_id.
REQ-023 When fifo_full is high, ready is forced low, the counter freezes and the grant is held.
REQ-024 If the granted requester deasserts valid mid-packet, the grant is held with no timeout. Non-granted valids are ignored.
REQ-025 A sole active requester is re-granted after a mandatory one-cycle IDLE gap.
REQ-026 Under saturation, no requester waits more than NUM_REQ-1 grants.
REQ-027 fifo_wr_en is never asserted while fifo_full is high.

Reset
REQ-028 While rst is high, on clk: state = IDLE, grant_id = 0, last_grant = NUM_REQ-1 (so requester 0 wins first), counter = 0.
REQ-029 During reset, busy = 0, req_ready = 0 and fifo_wr_en = 0.
REQ-030 Reset asserted mid-burst abandons the packet and writes no further beats.

Structure
REQ-031 The state enum (IDLE, GRANT) and the round-robin index-width helper belong in a shared package, arb_pkg.
REQ-032 One sub-module, rr_picker, is natural: combinational round-robin priority select (valid vector, last index -> next index, found flag).
REQ-033 The downstream sync FIFO stays external and is connected through fifo_full, fifo_wr_en and fifo_din.

Verification
REQ-034 Reset release, then req_valid = 4'b1111 with last on every beat: grants go 0,1,2,3,0. There is one IDLE cycle between each, and fifo_din[ID] matches the order.
REQ-035 Requester 2 sends 3 beats (0xA1, 0xA2, 0xA3, last on 3rd) while requester 1 is valid: all three beats are written consecutively with ID=2. Requester 1 is granted next.
REQ-036 MAX_BURST=4, requester 0 sends 10 beats without last: release after the 4th beat. Requester 0 is re-granted after 1 IDLE cycle.
REQ-037 fifo_full is held high for 5 cycles mid-burst: req_ready and fifo_wr_en are 0 throughout, the counter is unchanged, and the burst resumes with no lost or duplicated beat.
REQ-038 rst is pulsed for 1 cycle during beat 2 of a 6-beat packet: the next cycle shows IDLE, busy = 0 and no writes. The next grant goes to the lowest valid index.
REQ-039 Random valid/last/full stimulus for 10k cycles with a scoreboard: per-requester beat order is preserved, no write occurs while full, and fairness holds per REQ-026.
